// File: rtl/spi_regport_slave_pkg.sv
// Shared frame layout and state encoding for the SPI register-port slave.
package spi_regport_slave_pkg;

   localparam int RD_BIT     = 15;
   localparam int HALF_BIT   = 14;
   localparam int ADDR_LSB   = 0;
   localparam int ADDR_MSB   = 7;
   localparam int HDR_BITS   = 16;
   localparam int DATA_BITS  = 32;
   localparam int FRAME_BITS = HDR_BITS + DATA_BITS;
   localparam int CNT_W      = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_OVERRUN = 3'd4
   } state_e;

endpackage

// File: rtl/spi_regport_slave_sync.sv
// Multi-flop synchronizers for the three SPI pins plus edge detection on sen/sclk.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sen_i,
   input  logic sclk_i,
   input  logic mosi_i,
   output logic sen_o,
   output logic mosi_o,
   output logic sen_fall_o,
   output logic sen_rise_o,
   output logic sclk_rise_o,
   output logic sclk_fall_o
);

   logic [SYNC_STAGES-1:0] sen_q;
   logic [SYNC_STAGES-1:0] sclk_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   sen_prev_q;
   logic                   sclk_prev_q;

   // Reset loads the idle bus state so no spurious edge appears on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         sen_q       <= '1;
         sclk_q      <= '0;
         mosi_q      <= '0;
         sen_prev_q  <= 1'b1;
         sclk_prev_q <= 1'b0;
      end else begin
         sen_q       <= {sen_q[SYNC_STAGES-2:0], sen_i};
         sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
         mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
         sen_prev_q  <= sen_q[SYNC_STAGES-1];
         sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      end
   end

   assign sen_o       = sen_q[SYNC_STAGES-1];
   assign mosi_o      = mosi_q[SYNC_STAGES-1];
   assign sen_fall_o  =  sen_prev_q  & ~sen_q[SYNC_STAGES-1];
   assign sen_rise_o  = ~sen_prev_q  &  sen_q[SYNC_STAGES-1];
   assign sclk_rise_o = ~sclk_prev_q &  sclk_q[SYNC_STAGES-1];
   assign sclk_fall_o =  sclk_prev_q & ~sclk_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regport_slave.sv
// SPI mode-0 slave translating 48-bit frames into settings writes and readback reads.
module spi_regport_slave
   import spi_regport_slave_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RB_DEFAULT  = 32'h0BADC0DE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sen,
   input  logic        sclk,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   output logic        set_stb,
   output logic [7:0]  set_addr,
   output logic [31:0] set_data,
   output logic [7:0]  rb_addr,
   input  logic        rb_stb,
   input  logic [63:0] rb_data,
   output logic        frame_err
);

   localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FRM_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FRM      = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   logic sen_s, mosi_s, sen_fall, sen_rise, sclk_rise, sclk_fall;

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .reset       (reset),
      .sen_i       (sen),
      .sclk_i      (sclk),
      .mosi_i      (mosi),
      .sen_o       (sen_s),
      .mosi_o      (mosi_s),
      .sen_fall_o  (sen_fall),
      .sen_rise_o  (sen_rise),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall)
   );

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [HDR_BITS-2:0]    hdr_q;
   logic [DATA_BITS-2:0]   data_q;
   logic                   set_stb_q;
   logic [7:0]             set_addr_q;
   logic [31:0]            set_data_q;
   logic [7:0]             rb_addr_q;
   logic                   miso_q;
   logic                   frame_err_q;
   logic                   rb_got_q;
   logic                   rb_loaded_q;
   logic [31:0]            rb_word_q;
   logic [31:0]            rb_shift_q;
   logic [SYNC_STAGES:0]   settle_q;
   logic                   armed_q;

   logic [HDR_BITS-1:0]  hdr_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic [31:0]          rb_sel;
   logic [31:0]          rb_word_now;
   logic                 rb_miss;

   assign hdr_nxt     = {hdr_q, mosi_s};
   assign data_nxt    = {data_q, mosi_s};
   assign rb_sel      = hdr_q[HALF_BIT] ? rb_data[63:32] : rb_data[31:0];
   // On the 16th falling edge the strobe may arrive in that very cycle.
   assign rb_word_now = rb_got_q ? rb_word_q : (rb_stb ? rb_sel : RB_DEFAULT);
   assign rb_miss     = ~rb_got_q & ~rb_stb;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hdr_q       <= '0;
         data_q      <= '0;
         set_stb_q   <= 1'b0;
         set_addr_q  <= '0;
         set_data_q  <= '0;
         rb_addr_q   <= '0;
         miso_q      <= 1'b0;
         frame_err_q <= 1'b0;
         rb_got_q    <= 1'b0;
         rb_loaded_q <= 1'b0;
         rb_word_q   <= '0;
         rb_shift_q  <= '0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
      end else begin
         set_stb_q   <= 1'b0;
         frame_err_q <= 1'b0;
         // Only arm once the synchronizer has flushed and sen is seen idle,
         // so a frame already in progress across reset is never picked up.
         settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
         if (settle_q[SYNC_STAGES] && sen_s) armed_q <= 1'b1;
         if (state_q != ST_RD_DATA) miso_q <= 1'b0;

         if (sen_rise) begin
            if (state_q != ST_IDLE && cnt_q != '0 && cnt_q < CNT_FRM)
               frame_err_q <= 1'b1;
            state_q <= ST_IDLE;
         end else if (sen_fall && armed_q) begin
            state_q     <= ST_HDR;
            cnt_q       <= '0;
            rb_got_q    <= 1'b0;
            rb_loaded_q <= 1'b0;
         end else begin
            case (state_q)
               ST_HDR: begin
                  if (sclk_rise) begin
                     hdr_q <= hdr_nxt[HDR_BITS-2:0];
                     cnt_q <= cnt_q + CNT_ONE;
                     if (cnt_q == CNT_HDR_LAST) begin
                        if (hdr_nxt[RD_BIT]) begin
                           state_q   <= ST_RD_DATA;
                           rb_addr_q <= hdr_nxt[ADDR_MSB:ADDR_LSB];
                        end else begin
                           state_q <= ST_WR_DATA;
                        end
                     end
                  end
               end
               ST_WR_DATA: begin
                  if (sclk_rise) begin
                     data_q <= data_nxt[DATA_BITS-2:0];
                     cnt_q  <= cnt_q + CNT_ONE;
                     if (cnt_q == CNT_FRM_LAST) begin
                        state_q    <= ST_OVERRUN;
                        set_stb_q  <= 1'b1;
                        set_addr_q <= hdr_q[ADDR_MSB:ADDR_LSB];
                        set_data_q <= data_nxt;
                     end
                  end
               end
               ST_RD_DATA: begin
                  if (!rb_loaded_q && !rb_got_q && rb_stb) begin
                     rb_got_q  <= 1'b1;
                     rb_word_q <= rb_sel;
                  end
                  if (sclk_fall) begin
                     if (!rb_loaded_q) begin
                        rb_loaded_q <= 1'b1;
                        miso_q      <= rb_word_now[31];
                        rb_shift_q  <= {rb_word_now[30:0], 1'b0};
                        frame_err_q <= rb_miss;
                     end else begin
                        miso_q     <= rb_shift_q[31];
                        rb_shift_q <= {rb_shift_q[30:0], 1'b0};
                     end
                  end
                  if (sclk_rise) begin
                     cnt_q <= cnt_q + CNT_ONE;
                     if (cnt_q == CNT_FRM_LAST) state_q <= ST_OVERRUN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = ~sen_s;
   assign set_stb   = set_stb_q;
   assign set_addr  = set_addr_q;
   assign set_data  = set_data_q;
   assign rb_addr   = rb_addr_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regport_slave.sv
// Scoreboard bench for spi_regport_slave: writes, reads, aborts, overrun and mid-frame reset.
module tb_spi_regport_slave;

   localparam int HALF = 8;

   logic        clk, reset, sen, sclk, mosi;
   logic        miso, miso_oe, set_stb, rb_stb, frame_err;
   logic [7:0]  set_addr, rb_addr;
   logic [31:0] set_data;
   logic [63:0] rb_data;

   spi_regport_slave dut (
      .clk       (clk),
      .reset     (reset),
      .sen       (sen),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .set_stb   (set_stb),
      .set_addr  (set_addr),
      .set_data  (set_data),
      .rb_addr   (rb_addr),
      .rb_stb    (rb_stb),
      .rb_data   (rb_data),
      .frame_err (frame_err)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr_q[$];
   logic [31:0] exp_rd_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          stb_cnt = 0;
   int          err_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (set_stb) begin
            stb_cnt++;
            if (exp_wr_q.size() == 0) begin
               chk("stb_unexpected", 64'd1, 64'd0);
            end else begin
               wr_t e;
               e = exp_wr_q.pop_front();
               chk("set_addr", 64'(set_addr), 64'(e.addr));
               chk("set_data", 64'(set_data), 64'(e.data));
            end
         end
         if (frame_err) err_cnt++;
      end
   end

   task automatic sen_lo();
      @(negedge clk) sen = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic sen_hi();
      sen = 1'b1;
      repeat (3 * HALF) @(negedge clk);
   endtask

   // Shift n bits of v (left-aligned), capturing miso at each rising sclk.
   task automatic shift_bits(input logic [63:0] v, input int n,
                             output logic [31:0] rd, output logic [7:0] rba);
      rd  = '0;
      rba = '0;
      for (int i = 0; i < n; i++) begin
         mosi = v[63-i];
         repeat (HALF) @(negedge clk);
         if (i >= 16 && i < 48) rd[47-i] = miso;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         if (i == 19) rba = rb_addr;
         sclk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
   endtask

   task automatic run_frame(input logic [63:0] v, input int n,
                            output logic [31:0] rd, output logic [7:0] rba);
      sen_lo();
      shift_bits(v, n, rd, rba);
      sen_hi();
   endtask

   task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic [7:0]  rba;
      int s0, e0;
      s0 = stb_cnt;
      e0 = err_cnt;
      exp_wr_q.push_back('{addr: a, data: d});
      run_frame({8'h00, a, d, 16'h0}, 48, rd, rba);
      chk({tag, "_stb"}, 64'(stb_cnt - s0), 64'd1);
      chk({tag, "_err"}, 64'(err_cnt - e0), 64'd0);
   endtask

   task automatic do_read(input string tag, input logic [15:0] hdr, input logic stb,
                          input logic [31:0] exp, input int exp_err);
      logic [31:0] rd;
      logic [7:0]  rba;
      int e0;
      e0 = err_cnt;
      rb_stb = stb;
      exp_rd_q.push_back(exp);
      run_frame({hdr, 32'h0, 16'h0}, 48, rd, rba);
      chk({tag, "_rb_addr"}, 64'(rba), 64'(hdr[7:0]));
      chk({tag, "_miso"}, 64'(rd), 64'(exp_rd_q.pop_front()));
      chk({tag, "_err"}, 64'(err_cnt - e0), 64'(exp_err));
      rb_stb = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  rba;
      int s0, e0;
      reset = 1'b1; sen = 1'b1; sclk = 1'b0; mosi = 1'b0;
      rb_stb = 1'b0; rb_data = 64'h11223344_55667788;
      repeat (4) @(negedge clk);
      chk("rst_set_stb", 64'(set_stb), 64'd0);
      chk("rst_set_addr", 64'(set_addr), 64'd0);
      chk("rst_set_data", 64'(set_data), 64'd0);
      chk("rst_rb_addr", 64'(rb_addr), 64'd0);
      chk("rst_miso", 64'(miso), 64'd0);
      chk("rst_miso_oe", 64'(miso_oe), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Basic write, with output-enable and idle miso observed inside the frame.
      s0 = stb_cnt; e0 = err_cnt;
      exp_wr_q.push_back('{addr: 8'hA5, data: 32'hDEADBEEF});
      sen_lo();
      chk("oe_active", 64'(miso_oe), 64'd1);
      shift_bits({16'h00A5, 32'hDEADBEEF, 16'h0}, 48, rd, rba);
      chk("wr_miso_zero", 64'(rd), 64'd0);
      sen_hi();
      chk("oe_idle", 64'(miso_oe), 64'd0);
      chk("wr1_stb", 64'(stb_cnt - s0), 64'd1);
      chk("wr1_err", 64'(err_cnt - e0), 64'd0);

      do_read("rd_lo", 16'h8010, 1'b1, 32'h55667788, 0);
      do_read("rd_hi", 16'hC010, 1'b1, 32'h11223344, 0);
      do_read("rd_miss", 16'h8020, 1'b0, 32'h0BADC0DE, 1);

      // Abort after 30 bits, then a full write.
      s0 = stb_cnt; e0 = err_cnt;
      run_frame({16'h0042, 32'hFFFFFFFF, 16'h0}, 30, rd, rba);
      chk("abort_stb", 64'(stb_cnt - s0), 64'd0);
      chk("abort_err", 64'(err_cnt - e0), 64'd1);
      do_write("wr_after_abort", 8'h55, 32'hCAFEF00D);

      // 56-bit overrun frame: single strobe, silent end.
      s0 = stb_cnt; e0 = err_cnt;
      exp_wr_q.push_back('{addr: 8'h01, data: 32'h00000007});
      run_frame({16'h0001, 32'h00000007, 8'hFF, 8'h0}, 56, rd, rba);
      chk("ovr_stb", 64'(stb_cnt - s0), 64'd1);
      chk("ovr_err", 64'(err_cnt - e0), 64'd0);

      // Reset in the middle of a write frame.
      s0 = stb_cnt; e0 = err_cnt;
      sen_lo();
      shift_bits({16'h0009, 32'hFFFF0000, 16'h0}, 20, rd, rba);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      sen_hi();
      chk("rstmid_stb", 64'(stb_cnt - s0), 64'd0);
      chk("rstmid_err", 64'(err_cnt - e0), 64'd0);
      chk("rstmid_set_data", 64'(set_data), 64'd0);
      do_write("wr_after_rst", 8'h03, 32'h12345678);

      chk("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_regport_slave.md
SPI_REGPORT_SLAVE -- requirements
Module: spi_regport_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on sen/sclk/mosi.
REQ-002 SHALL have parameter RB_DEFAULT, default 32'h0BADC0DE: word shifted out when readback is not ready.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sen  input  1  SPI chip enable, active low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  SPI clock, idle low (mode 0), asynchronous to clk.
REQ-007 SHALL have port mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have port miso  output  1  serial data out, MSB first.
REQ-009 SHALL have port miso_oe  output  1  miso output enable.
REQ-010 SHALL have port set_stb  output  1  single-cycle settings write strobe.
REQ-011 SHALL have port set_addr  output  8  settings write address.
REQ-012 SHALL have port set_data  output  32  settings write data.
REQ-013 SHALL have port rb_addr  output  8  readback address.
REQ-014 SHALL have port rb_stb  input  1  readback data valid.
REQ-015 SHALL have port rb_data  input  64  readback data.
REQ-016 SHALL have port frame_err  output  1  single-cycle pulse on aborted frame or missed readback.

Function
REQ-017 Frame: 16-bit header then 32 data bits. Header bit15 = read (1) / write (0), bit14 = readback half select (1 = rb_data[63:32]), bits13:8 ignored, bits7:0 = address.
REQ-018 sen, sclk and mosi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized sclk, and mosi is sampled on synchronized rising edges.
REQ-019 Input timing contract: sclk high and low times are each at least SYNC_STAGES+3 clk cycles.
REQ-020 States: IDLE, HDR, WR_DATA, RD_DATA, OVERRUN. sen falling -> HDR with bit counter 0. After 16 header bits -> WR_DATA or RD_DATA. After 32 data bits -> OVERRUN. sen rising in any state -> IDLE.
REQ-021 Write completion: on the clk cycle after the 48th sampled bit, set_stb=1 for exactly one cycle. set_addr = header[7:0] and set_data = the 32 data bits, both held until the next write.
REQ-022 Read: rb_addr SHALL be driven with header[7:0] on the cycle after the 16th sampled bit and held until the frame ends.
REQ-023 The data word SHALL be captured from the half selected by bit14 on the first cycle with rb_stb=1, from rb_addr valid up to and including the 16th synchronized sclk falling edge.
REQ-024 If rb_stb is never seen in that window, the block SHALL shift RB_DEFAULT and pulse frame_err.
REQ-025 miso SHALL be updated on synchronized sclk falling edges: bit31 on the 16th falling edge, then one bit per falling edge. miso=0 in HDR, WR_DATA and OVERRUN.
REQ-026 miso_oe SHALL be 1 whenever synchronized sen is low, else 0.
REQ-027 Abort: sen rising with bit count in 1..47 SHALL discard the frame (no set_stb) and pulse frame_err. sen rising with count 0 or at least 48 SHALL be silent.
REQ-028 Bits beyond 48 (OVERRUN) SHALL be ignored and produce no second set_stb.
REQ-029 Simultaneous synchronized sen rising and sclk rising edge: the sen edge wins and the bit is discarded.

Reset
REQ-030 On reset: state=IDLE, bit counter=0, set_stb=0, set_addr=0, set_data=0, rb_addr=0, miso=0, miso_oe=0, frame_err=0, synchronizers loaded idle (sen=1, sclk=0).
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no set_stb and no frame_err. After reset, the block SHALL stay in IDLE until a fresh sen falling edge.

Structure
REQ-032 Frame field positions (read bit, half-select bit, address LSB/MSB, HDR_BITS=16, DATA_BITS=32) and the state encoding SHALL live in a shared package/include.
REQ-033 The synchronizer plus edge detect SHALL be one sub-module, spi_pin_sync, instantiated once for the three inputs. The rest is flat.

Verification
REQ-034 Write 0x00A5_DEADBEEF (header 0x00A5, data 0xDEADBEEF) -> one set_stb, set_addr=0xA5, set_data=0xDEADBEEF.
REQ-035 Read header 0x8010 with rb_stb=1, rb_data=0x11223344_55667788 -> rb_addr=0x10, miso shifts 0x55667788. Header 0xC010 -> 0x11223344.
REQ-036 Read header 0x8020 with rb_stb held 0 -> miso shifts 0x0BADC0DE, one frame_err pulse.
REQ-037 sen deasserted after 30 bits of a write -> no set_stb, one frame_err pulse. A following full write succeeds.
REQ-038 56-bit write frame (header 0x0001, data 0x00000007, 8 extra bits) -> exactly one set_stb with data 0x00000007, no frame_err.
REQ-039 reset pulsed after bit 20 of a write, then a full write 0x0003_12345678 -> exactly one set_stb with addr 0x03, data 0x12345678.
